// File: rtl/sevseg_capture.sv
// sevseg_capture: reconstructs per-digit BCD values from a multiplexed,
// active-low seven-segment bus. A (digit, pattern) pair is captured only
// after it has been sampled unchanged for STABLE_CYCLES synchronised cycles.
module sevseg_capture #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [6:0]            seg_n,
    input  logic [DIGITS-1:0]     an_n,
    input  logic                  clr_err,
    output logic [4*DIGITS-1:0]   digits,
    output logic [DIGITS-1:0]     digit_valid,
    output logic                  update,
    output logic                  err,
    output logic [2:0]            err_digit
);

    localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRACK = 2'd1,
        HELD  = 2'd2
    } state_t;

    logic [6:0]        seg_s1, seg_s2;
    logic [DIGITS-1:0] an_s1, an_s2;

    state_t            state;
    logic [7:0]        cnt;
    logic [DIGITS-1:0] ref_an;
    logic [6:0]        ref_seg;

    logic              cap_go;
    logic [2:0]        cap_idx;
    logic [6:0]        cap_seg;

    logic [3:0]        low_cnt_c;
    logic [2:0]        idx_c;
    logic              single_c;
    logic              same_c;
    logic [4:0]        dec_c;
    logic              blank_c;

    // Map an active-high segment pattern to {decodable, bcd}.
    function automatic logic [4:0] decode(input logic [6:0] p);
        case (p)
            7'b0111111: decode = {1'b1, 4'd0};
            7'b0000110: decode = {1'b1, 4'd1};
            7'b1011011: decode = {1'b1, 4'd2};
            7'b1001111: decode = {1'b1, 4'd3};
            7'b1100110: decode = {1'b1, 4'd4};
            7'b1101101: decode = {1'b1, 4'd5};
            7'b1111101: decode = {1'b1, 4'd6};
            7'b0000111: decode = {1'b1, 4'd7};
            7'b1111111: decode = {1'b1, 4'd8};
            7'b1101111: decode = {1'b1, 4'd9};
            default:    decode = 5'd0;
        endcase
    endfunction

    // Two-flop synchronisers; idle level is all-ones (nothing driven).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_s1 <= '1;
            seg_s2 <= '1;
            an_s1  <= '1;
            an_s2  <= '1;
        end else begin
            seg_s1 <= seg_n;
            seg_s2 <= seg_s1;
            an_s1  <= an_n;
            an_s2  <= an_s1;
        end
    end

    // Classify the synchronised sample: exactly one active anode is "single".
    always_comb begin
        low_cnt_c = 4'd0;
        idx_c     = 3'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!an_s2[i]) begin
                low_cnt_c = low_cnt_c + 4'd1;
                idx_c     = 3'(i);
            end
        end
        single_c = (low_cnt_c == 4'd1);
        same_c   = single_c && (an_s2 == ref_an) && (seg_s2 == ref_seg);
        dec_c    = decode(~cap_seg);
        blank_c  = (cap_seg == 7'h7F);
    end

    // Stability tracker; a capture request always refers to the current sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= 8'd0;
            ref_an  <= '1;
            ref_seg <= '1;
            cap_go  <= 1'b0;
            cap_idx <= 3'd0;
            cap_seg <= '1;
        end else begin
            cap_go  <= 1'b0;
            cap_idx <= idx_c;
            cap_seg <= seg_s2;
            case (state)
                IDLE: begin
                    if (single_c) begin
                        ref_an  <= an_s2;
                        ref_seg <= seg_s2;
                        cnt     <= 8'd1;
                        if (STABLE_MAX == 8'd1) begin
                            cap_go <= 1'b1;
                            state  <= HELD;
                        end else begin
                            state  <= TRACK;
                        end
                    end
                end
                TRACK: begin
                    if (!single_c) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (same_c) begin
                        if (cnt + 8'd1 >= STABLE_MAX) begin
                            cnt    <= STABLE_MAX;
                            cap_go <= 1'b1;
                            state  <= HELD;
                        end else begin
                            cnt    <= cnt + 8'd1;
                        end
                    end else begin
                        ref_an  <= an_s2;
                        ref_seg <= seg_s2;
                        cnt     <= 8'd1;
                        if (STABLE_MAX == 8'd1) begin
                            cap_go <= 1'b1;
                            state  <= HELD;
                        end
                    end
                end
                HELD: begin
                    if (!single_c) begin
                        state <= IDLE;
                        cnt   <= 8'd0;
                    end else if (!same_c) begin
                        ref_an  <= an_s2;
                        ref_seg <= seg_s2;
                        cnt     <= 8'd1;
                        if (STABLE_MAX == 8'd1) begin
                            cap_go <= 1'b1;
                        end else begin
                            state  <= TRACK;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 8'd0;
                end
            endcase
        end
    end

    // Apply a capture to its digit, flag changes and latch decode errors.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digits      <= '0;
            digit_valid <= '0;
            update      <= 1'b0;
            err         <= 1'b0;
            err_digit   <= 3'd0;
        end else begin
            update <= 1'b0;
            if (clr_err) begin
                err <= 1'b0;
            end
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_go && (cap_idx == 3'(i))) begin
                    if (dec_c[4]) begin
                        digits[4*i +: 4] <= dec_c[3:0];
                        digit_valid[i]   <= 1'b1;
                        update           <= !digit_valid[i] || (digits[4*i +: 4] != dec_c[3:0]);
                    end else begin
                        digit_valid[i]   <= 1'b0;
                        update           <= digit_valid[i];
                        if (!blank_c) begin
                            err       <= 1'b1;
                            err_digit <= cap_idx;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: doc/sevseg_capture.md
# sevseg_capture

Receive-side counterpart to the team's seven-segment encoder. It monitors a multiplexed, active-low seven-segment bus (segments plus per-digit anode enables) and reconstructs the BCD value shown on each digit. A pattern is captured only after it has been stable for a programmable number of cycles, so scan transitions and ghosting are ignored. Used in self-checking display paths and board-level loopback, between the display pins and the status/register logic.

## Interface
- `DIGITS`, default 4: number of multiplexed digits, legal range 1..8.
- `STABLE_CYCLES`, default 4: consecutive identical samples required before capture, legal range 1..255.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `seg_n`  in  7  segment bus, active-low; bit0=a … bit6=g. Asynchronous to `clk`.
- `an_n`  in  DIGITS  anode enables, active-low; bit i selects digit i. Asynchronous to `clk`.
- `clr_err`  in  1  single-cycle pulse that clears `err`.
- `digits`  out  4*DIGITS  captured BCD values; digit i occupies bits [4i+3:4i].
- `digit_valid`  out  DIGITS  digit i currently holds a decoded 0–9 value.
- `update`  out  1  one-cycle pulse when any `digits` or `digit_valid` bit changes.
- `err`  out  1  sticky flag: an undecodable pattern was captured.
- `err_digit`  out  3  index of the most recent digit that captured an undecodable pattern.

## Operation
- **Input synchronisation.** `seg_n` and `an_n` each pass through a 2-flop synchroniser. Both synchroniser stages reset to all-ones (inactive).
- **Decode, active-high view p = ~seg_n.**
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111, 4=1100110, 5=1101101, 6=1111101, 7=0000111, 8=1111111, 9=1101111.
  - p=0000000 means blank.
  - Any other p is invalid. Hex letters are not decoded.
- **Sample classification.** A synchronised sample is "single" when exactly one `an_n` bit is low. Zero or several low bits is "none".
- **FSM states.** IDLE, TRACK, HELD. An 8-bit stability counter `cnt` runs alongside.
  - IDLE: a single sample → TRACK with `cnt`=1 and the (anode, pattern) pair latched as reference.
  - TRACK:
    - a sample equal to the reference increments `cnt`;
    - when `cnt` reaches STABLE_CYCLES, capture and go to HELD;
    - a different single sample reloads the reference with `cnt`=1;
    - a none sample goes to IDLE.
  - HELD:
    - an equal sample stays in HELD, with no further capture;
    - a different single sample → TRACK with `cnt`=1;
    - a none sample → IDLE.
  - With STABLE_CYCLES=1, capture happens on the first single sample; the IDLE/TRACK entry captures directly and goes to HELD.
- **Capture for digit i.**
  - Valid value v: `digits[i]`=v, `digit_valid[i]`=1.
  - Blank: `digit_valid[i]`=0, `digits[i]` retained, no error.
  - Invalid: `digit_valid[i]`=0, `digits[i]` retained, `err`=1, `err_digit`=i.
  - Other digits are untouched.
- **`update`.** Asserted for the cycle after a capture, only if that capture changed `digits[i]` or `digit_valid[i]`.
- **`err` precedence.** `err` holds until `clr_err`. If `clr_err` and a new invalid capture occur in the same cycle, `err` stays 1.

## Timing
- **Reset values.** `digits`=0, `digit_valid`=0, `update`=0, `err`=0, `err_digit`=0; FSM in IDLE, `cnt`=0.
- **Capture latency.** Inputs first sampled stable at edge k are reflected on `digits`/`digit_valid` after edge k+STABLE_CYCLES+2. `update` is high for the cycle following that edge.
- **Dwell rule.** A dwell shorter than STABLE_CYCLES synchronised cycles never captures.
- **Reset mid-operation.** `rst` asserted mid-TRACK abandons the partial count immediately. No capture occurs after release until a fresh full dwell.
- **Repeat scans.** An identical re-scan of an already-captured digit captures again but does not pulse `update`.
- **Counter bounds.** `cnt` saturates at STABLE_CYCLES and never wraps.

## Test plan
- **Single digit.** STABLE_CYCLES=4; `an_n`=4'b1110, `seg_n`=7'b1000000 for 10 cycles → `digits[3:0]`=0, `digit_valid`=4'b0001, exactly one `update` pulse 6 cycles after the first sampling edge.
- **Full scan.** Scan digits 0..3 showing 1,2,3,4 at 8 cycles each → `digits`=16'h4321, `digit_valid`=4'hF. A second identical scan produces no `update`.
- **Glitch.** Digit 1 shows 7 for 3 cycles, then 8 for 8 cycles → `digits[7:4]`=8, and no capture of 7 ever occurs.
- **Invalid pattern and error clearing.**
  - Digit 2 with p=0101010 held 8 cycles → `digit_valid[2]`=0, `digits[11:8]` unchanged, `err`=1, `err_digit`=2.
  - `clr_err` alone → `err`=0.
  - `clr_err` in the same cycle as a new invalid capture → `err` stays 1.
- **Overlap and blank.**
  - `an_n`=4'b1100 for 20 cycles → no capture, no `err`.
  - Digit 0 blank (`seg_n`=7'h7F) for 8 cycles → `digit_valid[0]`=0, `err`=0.
- **Reset mid-dwell.** `rst` pulsed at `cnt`=3 of a digit-3 dwell → all outputs return to reset values. After release, capture occurs only after a full STABLE_CYCLES+2 dwell.
